serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial binary subtractor: computes diff = a - b - bin and a borrow-out, one bit per clock, LSB first.
- Counterpart to the combinational adder datapath. Adder sums in parallel; this block subtracts serially, for area-constrained arithmetic paths.
- Operands are accepted over a valid/ready start handshake.
- Results are returned over a valid/ready done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  operands a, b, bin are valid.
- start_ready  output  1  block can accept new operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- diff  output  WIDTH  result, (a - b - bin) mod 2^WIDTH.
- bout  output  1  final borrow-out.
- done_valid  output  1  diff and bout are valid.
- done_ready  input  1  consumer accepts the result.
- busy  output  1  high while in RUN or DONE.

Behaviour:
- Reset (async assert, takes effect immediately): state=IDLE; start_ready=1; done_valid=0; busy=0; diff=0; bout=0; internal shift registers, borrow register and bit counter cleared.
- Reset asserted mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On clk edge with start_valid=1: capture a into a_sh, b into b_sh, bin into borrow; clear counter and diff; go to RUN.
- RUN (start_ready=0, busy=1). Each edge:
  - d = a_sh[0] ^ b_sh[0] ^ borrow.
  - borrow <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - diff <= {d, diff[WIDTH-1:1]}.
  - a_sh, b_sh shift right one bit.
  - counter increments.
  - On the edge processing bit WIDTH-1: go to DONE and set bout to the final borrow.
- Counter width: $clog2(WIDTH+1). WIDTH=1 must work: one RUN cycle.
- Latency: done_valid rises exactly WIDTH clocks after the accepting edge.
- DONE:
  - done_valid=1; diff and bout held stable; start_ready=0.
  - On edge with done_ready=1: go to IDLE. diff and bout keep their values, but done_valid drops.
  - done_ready held low: wait indefinitely with outputs stable.
- No overlap: start_valid in RUN or DONE is ignored and must not alter operands.
- A new start is accepted the cycle after the DONE->IDLE transition at the earliest.
- Handshake rules:
  - Inputs a, b, bin are sampled only on the accepting edge; changes afterwards have no effect.
  - done_ready while done_valid=0 has no effect.
- Arithmetic: bout=1 iff a < b + bin (unsigned), so a - b - bin with full borrow chain equals {bout, diff} interpreted as a signed (WIDTH+1)-bit value with bout as sign.
- Synchronous logic only on clk; no combinational path from inputs to outputs except none (all outputs registered or state-decoded).

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, done_ready=1 -> done_valid high 8 clocks after accept, diff=0x1E, bout=0; IDLE next cycle.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Also a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1. Also a=0x10, b=0x10, bin=0 -> diff=0x00, bout=0.
- Backpressure and overlap: done_ready low 5 cycles after done_valid -> diff/bout/done_valid stable all 5 cycles. start_valid pulsed with a=0xAA during RUN and DONE -> ignored, result unchanged, start_ready stays 0.
- Input stability: change a and b on the cycle after acceptance -> result still reflects the captured values.
- Reset mid-RUN at bit 3 of a=0x80, b=0x01 -> immediately start_ready=1, busy=0, done_valid=0, diff=0, bout=0. Next operation a=0x03, b=0x01 -> diff=0x02, bout=0.
- Random regression: WIDTH in {1,8,13}, 1000 back-to-back operations with random done_ready stalls -> every {bout, diff} matches the reference model (a - b - bin) in WIDTH+1 bits. WIDTH=1 latency is 1 clock.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with valid/ready handshakes on operand capture and result delivery.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_sh_q, b_sh_q, diff_q;
    logic              borrow_q, bout_q;
    logic [CntW-1:0]   cnt_q;
    logic              start_ready_q, done_valid_q, busy_q;

    logic              bit_d, borrow_d, last_bit;
    logic [WIDTH-1:0]  diff_d;

    // Shift via >> so WIDTH=1 needs no special-cased part select.
    always_comb begin
        bit_d            = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
        borrow_d         = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
        diff_d           = diff_q >> 1;
        diff_d[WIDTH-1]  = bit_d;
        last_bit         = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            a_sh_q        <= '0;
            b_sh_q        <= '0;
            diff_q        <= '0;
            borrow_q      <= 1'b0;
            bout_q        <= 1'b0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        a_sh_q        <= a;
                        b_sh_q        <= b;
                        borrow_q      <= bin;
                        cnt_q         <= '0;
                        diff_q        <= '0;
                        state_q       <= StRun;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                StRun: begin
                    borrow_q <= borrow_d;
                    diff_q   <= diff_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        state_q      <= StDone;
                        bout_q       <= borrow_d;
                        done_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (done_ready) begin
                        state_q       <= StIdle;
                        done_valid_q  <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign done_valid  = done_valid_q;
    assign busy        = busy_q;
    assign diff        = diff_q;
    assign bout        = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed WIDTH=8 scenarios plus randomized
// scoreboard regressions at WIDTH 1, 8 and 13.
module tb_serial_subtractor;

    localparam int NOPS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit ddone   = 1'b0;
    logic r_rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout, expected DUT response", name);
    endtask

    // ---------------- directed instance, WIDTH=8 ----------------
    logic       d_rst, d_sv, d_sr, d_bin, d_bo, d_dv, d_dr, d_busy;
    logic [7:0] d_a, d_b, d_diff;
    logic [8:0] d_q[$];
    int         d_rx = 0;
    int         d_pushed = 0;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk         (clk),
        .rst         (d_rst),
        .start_valid (d_sv),
        .start_ready (d_sr),
        .a           (d_a),
        .b           (d_b),
        .bin         (d_bin),
        .diff        (d_diff),
        .bout        (d_bo),
        .done_valid  (d_dv),
        .done_ready  (d_dr),
        .busy        (d_busy)
    );

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        return r[8:0];
    endfunction

    initial forever begin
        @(negedge clk);
        if (d_dv && d_dr) begin
            if (d_q.size() == 0) fail_now("dir_unexpected_result");
            else begin
                check("dir_result", {55'd0, d_bo, d_diff}, {55'd0, d_q.pop_front()});
                d_rx++;
            end
        end
    end

    task automatic d_start(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int g;
        g = 0;
        while (!d_sr && g < 200) begin @(posedge clk); #1; g++; end
        if (!d_sr) fail_now("dir_start_ready_wait");
        d_a = a; d_b = b; d_bin = bin; d_sv = 1'b1;
        d_q.push_back(ref8(a, b, bin));
        d_pushed++;
        @(posedge clk); #1;
        d_sv = 1'b0;
    endtask

    task automatic d_wait_done(output int lat);
        lat = 0;
        while (!d_dv && lat < 200) begin @(posedge clk); #1; lat++; end
        if (!d_dv) fail_now("dir_done_wait");
    endtask

    logic [7:0] ta [4] = '{8'h00, 8'hFF, 8'h10, 8'hC3};
    logic [7:0] tb_v[4] = '{8'h01, 8'hFF, 8'h10, 8'h3C};
    logic       tbi [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int lat;
        d_rst = 1'b1; d_sv = 1'b0; d_a = '0; d_b = '0; d_bin = 1'b0; d_dr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start_ready", d_sr, 1);
        check("rst_busy", d_busy, 0);
        check("rst_done_valid", d_dv, 0);
        check("rst_diff", d_diff, 0);
        check("rst_bout", d_bo, 0);
        d_rst = 1'b0;

        d_start(8'h5A, 8'h3C, 1'b0);
        check("run_busy", d_busy, 1);
        check("run_start_ready", d_sr, 0);
        d_wait_done(lat);
        check("latency_w8", lat, 8);
        @(posedge clk); #1;
        check("idle_after_done", d_sr, 1);
        check("done_valid_dropped", d_dv, 0);
        check("diff_held_in_idle", d_diff, 8'h1E);

        for (int i = 0; i < 4; i++) begin
            d_start(ta[i], tb_v[i], tbi[i]);
            d_wait_done(lat);
            @(posedge clk); #1;
        end

        // Backpressure, overlap attempts and input changes after acceptance.
        d_dr = 1'b0;
        d_start(8'h37, 8'h12, 1'b1);
        d_a = 8'hAA; d_b = 8'h55; d_bin = 1'b0;
        repeat (3) begin
            d_sv = 1'b1;
            @(posedge clk); #1;
            check("overlap_run_start_ready", d_sr, 0);
            d_sv = 1'b0;
        end
        d_wait_done(lat);
        check("latency_with_overlap", lat, 5);
        repeat (5) begin
            d_sv = 1'b1;
            @(posedge clk); #1;
            check("stall_done_valid", d_dv, 1);
            check("stall_diff", d_diff, 8'h24);
            check("stall_bout", d_bo, 0);
            check("stall_start_ready", d_sr, 0);
        end
        d_sv = 1'b0;
        d_dr = 1'b1;
        @(posedge clk); #1;
        check("idle_after_stall", d_sr, 1);

        // Reset while bit 3 is in flight: no result must appear.
        d_start(8'h80, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        d_rst = 1'b1;
        d_q.delete();
        d_pushed--;
        #1;
        check("midrst_start_ready", d_sr, 1);
        check("midrst_busy", d_busy, 0);
        check("midrst_done_valid", d_dv, 0);
        check("midrst_diff", d_diff, 0);
        check("midrst_bout", d_bo, 0);
        @(posedge clk); #1;
        d_rst = 1'b0;
        d_start(8'h03, 8'h01, 1'b0);
        d_wait_done(lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("dir_result_count", d_rx, d_pushed);
        ddone = 1'b1;
    end

    // ---------------- randomized regressions ----------------
    initial begin
        r_rst = 1'b1;
        #22 r_rst = 1'b0;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int unsigned W = (gi == 0) ? 1 : ((gi == 1) ? 8 : 13);
        logic         sv, sr, bi, bo, dv, dr, by;
        logic [W-1:0] ra, rb, df;
        logic [W:0]   q[$];
        bit           fin = 1'b0;

        serial_subtractor #(.WIDTH(W)) u_dut (
            .clk         (clk),
            .rst         (r_rst),
            .start_valid (sv),
            .start_ready (sr),
            .a           (ra),
            .b           (rb),
            .bin         (bi),
            .diff        (df),
            .bout        (bo),
            .done_valid  (dv),
            .done_ready  (dr),
            .busy        (by)
        );

        initial begin
            dr = 1'b1;
            forever begin
                @(posedge clk); #1;
                dr = ($urandom_range(0, 3) != 0);
            end
        end

        initial forever begin
            @(negedge clk);
            if (dv && dr) begin
                if (q.size() == 0) fail_now($sformatf("rand_w%0d_unexpected", W));
                else check($sformatf("rand_w%0d_result", W), 64'({bo, df}), 64'(q.pop_front()));
            end
        end

        initial begin
            int g, lat;
            longint r;
            sv = 1'b0; ra = '0; rb = '0; bi = 1'b0;
            #1;
            wait (!r_rst);
            @(posedge clk); #1;
            for (int i = 0; i < NOPS; i++) begin
                g = 0;
                while (!sr && g < 200) begin @(posedge clk); #1; g++; end
                if (!sr) fail_now($sformatf("rand_w%0d_ready_wait", W));
                ra = W'($urandom);
                rb = W'($urandom);
                bi = 1'($urandom);
                r  = longint'(ra) - longint'(rb) - longint'(bi);
                q.push_back(r[W:0]);
                sv = 1'b1;
                @(posedge clk); #1;
                sv = 1'b0;
                lat = 0;
                while (!dv && lat < 200) begin @(posedge clk); #1; lat++; end
                if (!dv) fail_now($sformatf("rand_w%0d_done_wait", W));
                else if (i < 50) check($sformatf("rand_w%0d_latency", W), lat, W);
            end
            g = 0;
            while (q.size() != 0 && g < 500) begin @(posedge clk); #1; g++; end
            if (q.size() != 0) fail_now($sformatf("rand_w%0d_drain", W));
            fin = 1'b1;
        end
    end

    initial begin
        int g;
        g = 0;
        while (!(ddone && g_rand[0].fin && g_rand[1].fin && g_rand[2].fin) && g < 60000) begin
            @(posedge clk);
            g++;
        end
        if (g >= 60000) fail_now("global_cycle_budget");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
